// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO in front of it.
// Sends 8N1 frames, LSB first, with DELAY_FRAMES clock cycles per bit.
// When more bytes are queued, frames go out back to back with no idle gap.
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        uart_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DELAY_FRAMES);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(DELAY_FRAMES - 1);
  localparam logic [AW:0]   DEPTH      = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, stateNext;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic [CW-1:0] cycleCnt, cycleNext;
  logic [2:0]    bitCnt, bitNext;
  logic [7:0]    shiftReg, shiftNext;
  logic          txReg, txNext;
  logic          push, pop;

  // A full FIFO never accepts, even in the cycle it pops (no bypass path).
  assign in_ready   = rst_n && (count < DEPTH);
  assign push       = in_valid && in_ready;
  assign uart_tx    = txReg;
  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;

  // Byte storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= in_data;
  end

  // FIFO pointers and occupancy; push and pop in one cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Transmit FSM state, bit timing and registered line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cycleCnt <= '0;
      bitCnt   <= '0;
      txReg    <= 1'b1;
    end else begin
      state    <= stateNext;
      cycleCnt <= cycleNext;
      bitCnt   <= bitNext;
      txReg    <= txNext;
    end
  end

  // Shift register holds the frame byte; bit 0 is always the bit on the line.
  always_ff @(posedge clk) begin
    shiftReg <= shiftNext;
  end

  // Next-state logic; txNext is the level of the cycle being entered so the
  // registered output lines up exactly with the state it belongs to.
  always_comb begin
    stateNext = state;
    cycleNext = cycleCnt;
    bitNext   = bitCnt;
    shiftNext = shiftReg;
    txNext    = txReg;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        txNext = 1'b1;
        if (count != '0) begin
          pop       = 1'b1;
          stateNext = START;
          cycleNext = '0;
          bitNext   = '0;
          shiftNext = mem[rdPtr];
          txNext    = 1'b0;
        end
      end
      START: begin
        if (cycleCnt == LAST_CYCLE) begin
          stateNext = DATA;
          cycleNext = '0;
          txNext    = shiftReg[0];
        end else begin
          cycleNext = cycleCnt + 1'b1;
          txNext    = 1'b0;
        end
      end
      DATA: begin
        if (cycleCnt == LAST_CYCLE) begin
          cycleNext = '0;
          if (bitCnt == 3'd7) begin
            stateNext = STOP;
            txNext    = 1'b1;
          end else begin
            bitNext   = bitCnt + 1'b1;
            shiftNext = {1'b0, shiftReg[7:1]};
            txNext    = shiftReg[1];
          end
        end else begin
          cycleNext = cycleCnt + 1'b1;
        end
      end
      STOP: begin
        txNext = 1'b1;
        if (cycleCnt == LAST_CYCLE) begin
          cycleNext = '0;
          if (count != '0) begin
            pop       = 1'b1;
            stateNext = START;
            bitNext   = '0;
            shiftNext = mem[rdPtr];
            txNext    = 1'b0;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          cycleNext = cycleCnt + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        txNext    = 1'b1;
      end
    endcase
  end

endmodule
